// File: rtl/mem_access_ctrl.sv
// Initiator for a single-port synchronous memory: accepts single-word writes and
// burst reads, range-checks them up front, and returns one response word per beat.
module mem_access_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 16384,
  parameter int LEN_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  // Both channels use strict valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; a raised valid and its payload hold until then.
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_last,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR     = 3'd1,
    ST_RD_MEM = 3'd2,
    ST_RD_CAP = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(MEM_DEPTH - 1);

  state_e              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_last_q, rsp_last_d;
  logic                rsp_error_q, rsp_error_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_data_in_q, mem_data_in_d;
  logic                mem_we_q, mem_we_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;

  logic                req_fire;
  logic                rsp_fire;
  logic [ADDR_W:0]     rd_end;
  logic                wr_ok;
  logic                rd_ok;

  assign req_fire = req_valid && req_ready_q;
  assign rsp_fire = rsp_valid_q && rsp_ready;

  // One extra bit on the end address so a burst near the top cannot wrap past the check.
  assign rd_end = {1'b0, req_addr} + (ADDR_W+1)'(req_len);
  assign wr_ok  = ({1'b0, req_addr} < DEPTH_C);
  assign rd_ok  = (rd_end <= LAST_C);

  always_comb begin
    state_d       = state_q;
    req_ready_d   = req_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_last_d    = rsp_last_q;
    rsp_error_d   = rsp_error_q;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    mem_we_d      = mem_we_q;
    cnt_d         = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          req_ready_d = 1'b0;
          if ((req_write && !wr_ok) || (!req_write && !rd_ok)) begin
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_last_d  = 1'b1;
            rsp_rdata_d = '0;
            state_d     = ST_RESP;
          end else if (req_write) begin
            mem_addr_d    = req_addr;
            mem_data_in_d = req_wdata;
            mem_we_d      = 1'b1;
            state_d       = ST_WR;
          end else begin
            mem_addr_d = req_addr;
            cnt_d      = req_len;
            state_d    = ST_RD_MEM;
          end
        end
      end

      ST_WR: begin
        mem_we_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_last_d  = 1'b1;
        rsp_error_d = 1'b0;
        rsp_rdata_d = '0;
        state_d     = ST_RESP;
      end

      ST_RD_MEM: begin
        state_d = ST_RD_CAP;
      end

      ST_RD_CAP: begin
        rsp_rdata_d = mem_data_out;
        rsp_valid_d = 1'b1;
        rsp_last_d  = (cnt_q == '0);
        rsp_error_d = 1'b0;
        state_d     = ST_RESP;
      end

      ST_RESP: begin
        if (rsp_fire) begin
          rsp_valid_d = 1'b0;
          if (!rsp_last_q) begin
            cnt_d      = cnt_q - LEN_W'(1);
            mem_addr_d = mem_addr_q + ADDR_W'(1);
            state_d    = ST_RD_MEM;
          end else begin
            rsp_error_d = 1'b0;
            req_ready_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end

      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        mem_we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_last_q    <= 1'b0;
      rsp_error_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      mem_we_q      <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_last_q    <= rsp_last_d;
      rsp_error_q   <= rsp_error_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      mem_we_q      <= mem_we_d;
      cnt_q         <= cnt_d;
    end
  end

  assign req_ready        = req_ready_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_rdata        = rsp_rdata_q;
  assign rsp_last         = rsp_last_q;
  assign rsp_error        = rsp_error_q;
  assign mem_addr         = mem_addr_q;
  assign mem_data_in      = mem_data_in_q;
  assign mem_write_enable = mem_we_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural 16Ki x 16 synchronous memory.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [3:0]  req_len;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_last;
  logic        rsp_error;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic        mem_write_enable;
  logic [15:0] mem_data_out;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int we_cycles = 0;
  logic [15:0] max_addr = 16'h0000;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_last(rsp_last), .rsp_error(rsp_error),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_write_enable(mem_write_enable), .mem_data_out(mem_data_out),
    .dbg_state(dbg_state)
  );

  // Memory model: write on enable, registered read of the presented address.
  logic [15:0] mem_arr [0:16383];
  always @(posedge clk) begin
    if (mem_write_enable === 1'b1) mem_arr[mem_addr[13:0]] <= mem_data_in;
    mem_data_out <= mem_arr[mem_addr[13:0]];
  end

  always @(negedge clk) begin
    if (mem_write_enable === 1'b1) we_cycles++;
    if (!$isunknown(mem_addr) && mem_addr > max_addr) max_addr = mem_addr;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents a request at a falling edge; returns at the falling edge after acceptance.
  task automatic do_req(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                        input logic [3:0] len);
    int k = 0;
    while (req_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    check("req_ready_before_req", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_len = len;
    @(negedge clk);
    req_valid = 1'b0;
    check("req_ready_drops", {31'b0, req_ready}, 32'd0);
  endtask

  task automatic get_rsp(input string tag, input logic [15:0] exp_data, input logic exp_last,
                         input logic exp_err, input int exp_lat, input int stall);
    int k = 0;
    while (rsp_valid !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    if (rsp_valid !== 1'b1) begin
      check({tag, "_timeout"}, {31'b0, rsp_valid}, 32'd1);
      return;
    end
    if (exp_lat >= 0) check({tag, "_latency"}, k, exp_lat);
    check({tag, "_rdata"}, {16'b0, rsp_rdata}, {16'b0, exp_data});
    check({tag, "_last"}, {31'b0, rsp_last}, {31'b0, exp_last});
    check({tag, "_error"}, {31'b0, rsp_error}, {31'b0, exp_err});
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check({tag, "_stall_valid"}, {31'b0, rsp_valid}, 32'd1);
      check({tag, "_stall_rdata"}, {16'b0, rsp_rdata}, {16'b0, exp_data});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_valid_after_hs"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  task automatic do_write(input string tag, input logic [15:0] addr, input logic [15:0] data);
    do_req(1'b1, addr, data, 4'd0);
    check({tag, "_we_high"}, {31'b0, mem_write_enable}, 32'd1);
    get_rsp(tag, 16'h0000, 1'b1, 1'b0, 1, 0);
    check({tag, "_we_low"}, {31'b0, mem_write_enable}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, "_rsp_rdata"}, {16'b0, rsp_rdata}, 32'd0);
    check({tag, "_rsp_last"}, {31'b0, rsp_last}, 32'd0);
    check({tag, "_rsp_error"}, {31'b0, rsp_error}, 32'd0);
    check({tag, "_mem_addr"}, {16'b0, mem_addr}, 32'd0);
    check({tag, "_mem_data_in"}, {16'b0, mem_data_in}, 32'd0);
    check({tag, "_mem_we"}, {31'b0, mem_write_enable}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] addr_before;
    int k;
    reset = 1'b1; rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0005; req_wdata = 16'hDEAD; req_len = 4'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_ignores_req_we", we_cycles, 0);
    req_valid = 1'b0;
    reset = 1'b0;

    // Write then single-word read
    do_write("wr_beef", 16'h0010, 16'hBEEF);
    do_req(1'b0, 16'h0010, 16'h0000, 4'd0);
    get_rsp("rd_beef", 16'hBEEF, 1'b1, 1'b0, 2, 0);

    // Burst read with backpressure
    for (int i = 0; i < 4; i++) do_write("preload", 16'h0100 + 16'(i), 16'hA000 + 16'(i));
    do_req(1'b0, 16'h0100, 16'h0000, 4'd3);
    get_rsp("burst0", 16'hA000, 1'b0, 1'b0, 2, 0);
    get_rsp("burst1", 16'hA001, 1'b0, 1'b0, 2, 2);
    get_rsp("burst2", 16'hA002, 1'b0, 1'b0, 2, 2);
    get_rsp("burst3", 16'hA003, 1'b1, 1'b0, 2, 0);

    // Boundary burst over the top 16 words
    for (int i = 0; i < 16; i++) do_write("top_fill", 16'h3FF0 + 16'(i), 16'h5000 + 16'(i));
    do_req(1'b0, 16'h3FF0, 16'h0000, 4'd15);
    for (int i = 0; i < 16; i++) begin
      get_rsp("top_rd", 16'h5000 + 16'(i), (i == 15), 1'b0, 2, 0);
    end
    check("top_last_addr", {16'b0, mem_addr}, 32'h3FFF);

    // Range errors
    k = we_cycles;
    do_req(1'b1, 16'h4000, 16'h7777, 4'd0);
    get_rsp("wr_oob", 16'h0000, 1'b1, 1'b1, 0, 0);
    check("wr_oob_no_we", we_cycles, k);
    do_req(1'b0, 16'h3FFE, 16'h0000, 4'd1);
    get_rsp("rd_edge0", 16'h500E, 1'b0, 1'b0, 2, 0);
    get_rsp("rd_edge1", 16'h500F, 1'b1, 1'b0, 2, 0);
    addr_before = mem_addr;
    do_req(1'b0, 16'h3FFE, 16'h0000, 4'd2);
    get_rsp("rd_oob", 16'h0000, 1'b1, 1'b1, 0, 0);
    check("rd_oob_addr_held", {16'b0, mem_addr}, {16'b0, addr_before});

    // Reset while the second word of a len-7 burst waits in RESP
    do_req(1'b0, 16'h0100, 16'h0000, 4'd7);
    get_rsp("rst_burst0", 16'hA000, 1'b0, 1'b0, 2, 0);
    k = 0;
    while (rsp_valid !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    check("rst_burst1_rdata", {16'b0, rsp_rdata}, 32'hA001);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("rst_burst");
    do_req(1'b0, 16'h0010, 16'h0000, 4'd0);
    get_rsp("after_rst_rd", 16'hBEEF, 1'b1, 1'b0, 2, 0);

    // Reset on the WR edge: write lands, no ack
    do_req(1'b1, 16'h0020, 16'h1234, 4'd0);
    check("rst_wr_we_high", {31'b0, mem_write_enable}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("rst_wr");
    repeat (3) begin
      @(negedge clk);
      check("rst_wr_no_ack", {31'b0, rsp_valid}, 32'd0);
    end
    do_req(1'b0, 16'h0020, 16'h0000, 4'd0);
    get_rsp("rst_wr_readback", 16'h1234, 1'b1, 1'b0, 2, 0);

    check("we_cycle_total", we_cycles, 22);
    check("max_mem_addr", {16'b0, max_addr}, 32'h3FFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
